mem_arbiter: RTL

Shared-memory arbiter for the five-stage pipeline. It lets the IF-stage instruction fetch and the MEM-stage load/store share one single-port, fixed-latency memory. It serialises requests, drives the memory port, returns read data with a one-cycle ready pulse, and raises stall signals that hold the requesting stage while its access is outstanding. Both requesters sit on the core clock; the memory sits behind this block.

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the instruction fetch and the load/store unit share one
// single-port, fixed-latency memory. One transaction is in flight at a time.
// Each transaction runs IDLE -> ISSUE -> WAIT -> DONE. The owner's Ready
// pulses for one cycle in DONE, and the requester stalls until that pulse.
module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IReq,
  input  logic [ADDR_WIDTH-1:0] IAddr,
  output logic [DATA_WIDTH-1:0] IData,
  output logic                  IReady,
  input  logic                  DReq,
  input  logic                  DWrite,
  input  logic [ADDR_WIDTH-1:0] DAddr,
  input  logic [DATA_WIDTH-1:0] DWData,
  output logic [DATA_WIDTH-1:0] DRData,
  output logic                  DReady,
  output logic                  StallIF,
  output logic                  StallMEM,
  output logic                  MemEn,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWData,
  input  logic [DATA_WIDTH-1:0] MemRData
);

  // The counter must hold MEM_LATENCY-1. Keep it at least one bit wide
  // so that MEM_LATENCY = 1 still works.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             owner_d;    // 1 = data port owns the current transaction
  logic             last_d;     // 1 = most recent grant went to the data port
  logic             any_req;
  logic             grant_d;    // arbitration result, meaningful only in IDLE
  logic             grant;
  logic             capture;    // MemRData is valid in this cycle

  assign any_req = IReq | DReq;
  // A lone request wins. On a tie, the side that did not win last time wins.
  assign grant_d = DReq & (~IReq | ~last_d);
  // Requests are sampled only in IDLE. DONE ignores them, so a requester
  // still holding its request during its Ready cycle is not granted again.
  assign grant   = (state == IDLE) & any_req;
  assign capture = (state == WAIT) & (cnt == '0);

  assign StallIF  = IReq & ~IReady;
  assign StallMEM = DReq & ~DReady;

  // Next-state selection for the transaction sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state, latency countdown and ownership / fairness tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      owner_d <= 1'b0;
      last_d  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner_d <= grant_d;
        last_d  <= grant_d;
      end
      if (state == ISSUE) begin
        cnt <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Memory port registers. These latch the grantee's request at the grant
  // edge, so later changes on the request inputs have no effect. A fetch
  // has no write data and leaves MemWData at its previous value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MemEn    <= 1'b0;
      MemWrite <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
    end else begin
      MemEn <= grant;
      if (grant) begin
        MemWrite <= grant_d & DWrite;
        MemAddr  <= grant_d ? DAddr : IAddr;
        if (grant_d) MemWData <= DWData;
      end
    end
  end

  // Response capture and completion pulses. A reset discards a response
  // that is still in flight because the sequencer never reaches capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IData  <= '0;
      DRData <= '0;
      IReady <= 1'b0;
      DReady <= 1'b0;
    end else begin
      IReady <= capture & ~owner_d;
      DReady <= capture & owner_d;
      if (capture && !owner_d) IData <= MemRData;
      // A store returns nothing, so DRData keeps the last load result.
      if (capture && owner_d && !MemWrite) DRData <= MemRData;
    end
  end

endmodule
